// File: rtl/spi_flash_responder.sv
// spi_flash_responder
//
// Purpose:
//   SPI mode-0 flash responder. It answers the 0x03 READ transaction: an
//   opcode byte, then a 24-bit byte address, then data bytes for as long as
//   chip select stays low. Words come from a backing memory that has a
//   1-cycle read port. SCK, CS_N and MOSI are oversampled in the clk domain,
//   so clk must run at least 8x SCK. A read runs sequentially through memory:
//   the next word is prefetched when lane 3 of the current word is loaded.
//
// Ports:
//   clk_i        system clock, rising edge
//   resetn_i     synchronous active-low reset
//   sck_i        SPI clock from the initiator (asynchronous to clk_i)
//   cs_n_i       chip select, active low (asynchronous to clk_i)
//   mosi_i       initiator -> responder serial data
//   miso_o       responder -> initiator serial data
//   mem_addr_o   word address for the backing memory
//   mem_rstrb_o  one-cycle read strobe; mem_rdata_i is valid the next clk
//   mem_rdata_i  word read back; byte lane 0 is bits [7:0]
//   busy_o       high while a transaction is in progress
//   cmd_err_o    one-cycle pulse when a non-READ opcode has been received
module spi_flash_responder #(
    parameter int         ADDR_W       = 20,
    parameter logic [7:0] CMD_READ     = 8'h03,
    parameter int         DUMMY_CLOCKS = 0
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    input  logic              sck_i,
    input  logic              cs_n_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_rstrb_o,
    input  logic [31:0]       mem_rdata_i,
    output logic              busy_o,
    output logic              cmd_err_o
);

    localparam int DCW = (DUMMY_CLOCKS > 1) ? $clog2(DUMMY_CLOCKS) : 1;
    localparam logic [DCW-1:0] DUMMY_LAST =
        DCW'((DUMMY_CLOCKS > 0) ? DUMMY_CLOCKS - 1 : 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        ADDR   = 3'd2,
        IGNORE = 3'd3,
        DUMMY  = 3'd4,
        DATA   = 3'd5
    } state_e;

    state_e state_q, state_d;

    // Synchronizer stages and edge-detect history.
    logic sckMeta_q, sckSync_q, sckPrev_q;
    logic csMeta_q, csSync_q, csPrev_q;
    logic mosiMeta_q, mosiSync_q;
    logic [1:0] warm_q;
    logic armed_q;

    // Datapath registers.
    logic [4:0]        bitCnt_q;
    logic [2:0]        txBit_q;
    logic [DCW-1:0]    dummyCnt_q;
    logic [ADDR_W:0]   shift_q;
    logic [1:0]        laneIdx_q;
    logic [31:0]       word_q;
    logic              fetchPend_q;
    logic [6:0]        txShift_q;
    logic              misoBit_q;
    logic [ADDR_W-1:0] memAddr_q;
    logic              memRstrb_q;
    logic              cmdErr_q;

    logic sckRise, sckFall, csFall, abort;
    logic [ADDR_W:0]   shiftNext;
    logic [ADDR_W+1:0] byteAddr;
    logic [7:0]        opcodeNext;
    logic [7:0]        laneByte;

    // Edge events come from the synchronized copies. The serial data is
    // delayed by the same two stages as SCK, so MOSI lines up with its rise.
    // A CS_N fall counts only once a genuine high level has been seen after
    // reset. A reset that lands in the middle of a transaction therefore
    // leaves the responder idle until the initiator starts a new one.
    assign sckRise    = sckSync_q & ~sckPrev_q;
    assign sckFall    = ~sckSync_q & sckPrev_q;
    assign csFall     = armed_q & csPrev_q & ~csSync_q;
    assign abort      = (state_q != IDLE) && csSync_q;
    assign shiftNext  = {shift_q[ADDR_W-1:0], mosiSync_q};
    assign byteAddr   = {shift_q, mosiSync_q};
    assign opcodeNext = shiftNext[7:0];

    // Two-flop synchronizers plus a third flop for edge detection. warm_q
    // counts the clocks after reset until every stage holds a real sample.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            sckMeta_q  <= 1'b0;
            sckSync_q  <= 1'b0;
            sckPrev_q  <= 1'b0;
            csMeta_q   <= 1'b1;
            csSync_q   <= 1'b1;
            csPrev_q   <= 1'b1;
            mosiMeta_q <= 1'b0;
            mosiSync_q <= 1'b0;
            warm_q     <= 2'd0;
            armed_q    <= 1'b0;
        end else begin
            sckMeta_q  <= sck_i;
            sckSync_q  <= sckMeta_q;
            sckPrev_q  <= sckSync_q;
            csMeta_q   <= cs_n_i;
            csSync_q   <= csMeta_q;
            csPrev_q   <= csSync_q;
            mosiMeta_q <= mosi_i;
            mosiSync_q <= mosiMeta_q;
            if (warm_q != 2'd3) begin
                warm_q <= warm_q + 2'd1;
            end
            if ((warm_q == 2'd3) && csSync_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Deselection overrides every other transition.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (csFall) begin
                        state_d = CMD;
                    end
                end
                CMD: begin
                    if (sckRise && (bitCnt_q == 5'd7)) begin
                        state_d = (opcodeNext == CMD_READ) ? ADDR : IGNORE;
                    end
                end
                ADDR: begin
                    if (sckRise && (bitCnt_q == 5'd23)) begin
                        state_d = (DUMMY_CLOCKS == 0) ? DATA : DUMMY;
                    end
                end
                DUMMY: begin
                    if (sckRise && (dummyCnt_q == DUMMY_LAST)) begin
                        state_d = DATA;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Selects the byte lane that the next load hands to the MISO shifter.
    always_comb begin
        laneByte = word_q[7:0];
        case (laneIdx_q)
            2'd0: laneByte = word_q[7:0];
            2'd1: laneByte = word_q[15:8];
            2'd2: laneByte = word_q[23:16];
            2'd3: laneByte = word_q[31:24];
            default: laneByte = word_q[7:0];
        endcase
    end

    // Datapath. The shift register is only ADDR_W+1 bits wide, so the high
    // address bits fall off the top as they are shifted in. A fetch result
    // that is still in flight when chip select rises is thrown away.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            bitCnt_q    <= '0;
            txBit_q     <= '0;
            dummyCnt_q  <= '0;
            shift_q     <= '0;
            laneIdx_q   <= '0;
            word_q      <= '0;
            fetchPend_q <= 1'b0;
            txShift_q   <= '0;
            misoBit_q   <= 1'b0;
            memAddr_q   <= '0;
            memRstrb_q  <= 1'b0;
            cmdErr_q    <= 1'b0;
        end else begin
            memRstrb_q  <= 1'b0;
            cmdErr_q    <= 1'b0;
            fetchPend_q <= memRstrb_q;
            if (fetchPend_q) begin
                word_q <= mem_rdata_i;
            end
            if (abort) begin
                bitCnt_q    <= '0;
                txBit_q     <= '0;
                dummyCnt_q  <= '0;
                shift_q     <= '0;
                laneIdx_q   <= '0;
                word_q      <= '0;
                fetchPend_q <= 1'b0;
                txShift_q   <= '0;
                misoBit_q   <= 1'b0;
            end else begin
                case (state_q)
                    CMD: begin
                        if (sckRise) begin
                            shift_q <= shiftNext;
                            if (bitCnt_q == 5'd7) begin
                                bitCnt_q <= '0;
                                if (opcodeNext != CMD_READ) begin
                                    cmdErr_q <= 1'b1;
                                end
                            end else begin
                                bitCnt_q <= bitCnt_q + 5'd1;
                            end
                        end
                    end
                    ADDR: begin
                        if (sckRise) begin
                            shift_q <= shiftNext;
                            if (bitCnt_q == 5'd23) begin
                                bitCnt_q   <= '0;
                                memAddr_q  <= byteAddr[ADDR_W+1:2];
                                laneIdx_q  <= byteAddr[1:0];
                                memRstrb_q <= 1'b1;
                            end else begin
                                bitCnt_q <= bitCnt_q + 5'd1;
                            end
                        end
                    end
                    DUMMY: begin
                        if (sckRise) begin
                            dummyCnt_q <= dummyCnt_q + DCW'(1);
                        end
                    end
                    DATA: begin
                        // On the first fall of each byte, load a new lane.
                        // Loading lane 3 also prefetches the next word, which
                        // then has a whole byte time to arrive.
                        if (sckFall) begin
                            txBit_q <= txBit_q + 3'd1;
                            if (txBit_q == 3'd0) begin
                                misoBit_q <= laneByte[7];
                                txShift_q <= laneByte[6:0];
                                laneIdx_q <= laneIdx_q + 2'd1;
                                if (laneIdx_q == 2'd3) begin
                                    memAddr_q  <= memAddr_q + 1'b1;
                                    memRstrb_q <= 1'b1;
                                end
                            end else begin
                                misoBit_q <= txShift_q[6];
                                txShift_q <= {txShift_q[5:0], 1'b0};
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Output logic. MISO carries data only in DATA and is held low elsewhere.
    always_comb begin
        miso_o      = (state_q == DATA) ? misoBit_q : 1'b0;
        busy_o      = (state_q != IDLE);
        mem_addr_o  = memAddr_q;
        mem_rstrb_o = memRstrb_q;
        cmd_err_o   = cmdErr_q;
    end

endmodule
